// File: rtl/vend_transaction_controller.sv
// vend_transaction_controller
// Sequences one vending transaction. It collects coin credit, checks the
// selected product against its price, runs the dispense handshake, and then
// pays change one CHANGE_UNIT coin at a time through the hopper handshake.
// It also handles buy-more, cancel/refund and inactivity timeout.
//
// Optional feature macro: VEND_STATS_EN adds saturating vend_count and
// refund_count outputs.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   coin_valid, coin_value     coin strobe and value from the acceptor
//   coin_accept, coin_reject   one-cycle coin result pulses
//   select_valid, product_select  keypad strobe and product code
//   buy_more                   keep residual credit, sampled with vend_ack
//   cancel                     refund request strobe
//   vend_req / vend_ack        dispense handshake (req held until ack)
//   chg_req / chg_ack          change hopper handshake, one unit per ack
//   credit                     current credit
//   insufficient               one-cycle pulse, selection refused
//   busy                       high whenever the FSM is not in IDLE
//   vend_count, refund_count   (VEND_STATS_EN only) saturating statistics
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no credit; the first acceptable coin starts a transaction
// COLLECT | accumulating credit; waits for select, cancel or timeout
// VEND    | vend_req held until the dispense mechanism acks
// CHANGE  | paying out credit in CHANGE_UNIT steps; remainder forfeited
module vend_transaction_controller #(
   parameter logic [7:0] PRICE_0     = 8'd25,
   parameter logic [7:0] PRICE_1     = 8'd50,
   parameter logic [7:0] PRICE_2     = 8'd75,
   parameter logic [7:0] CREDIT_MAX  = 8'd200,
   parameter logic [7:0] CHANGE_UNIT = 8'd5,
   parameter int         TIMEOUT_CYC = 1000,
   parameter int         TMR_W       = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [7:0] coin_value,
   output logic       coin_accept,
   output logic       coin_reject,
   input  logic       select_valid,
   input  logic [1:0] product_select,
   input  logic       buy_more,
   input  logic       cancel,
   output logic       vend_req,
   input  logic       vend_ack,
   output logic       chg_req,
   input  logic       chg_ack,
   output logic [7:0] credit,
   output logic       insufficient,
   output logic       busy
`ifdef VEND_STATS_EN
   ,
   output logic [15:0] vend_count,
   output logic [15:0] refund_count
`endif
);

   typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

   state_t            state, state_nx;
   logic [7:0]        credit_nx;
   logic [TMR_W-1:0]  timer, timer_nx;
   logic              coin_accept_nx, coin_reject_nx, insufficient_nx;
   logic              vend_req_nx, chg_req_nx;
   logic              to_refund;
   logic [8:0]        coin_sum;
   logic [7:0]        price;
   logic              code_ok;

   // Nine-bit sum so an overflowing coin can never alias under CREDIT_MAX.
   assign coin_sum = {1'b0, credit} + {1'b0, coin_value};

   always_comb begin
      price   = PRICE_0;
      code_ok = 1'b1;
      case (product_select)
         2'b00:   price = PRICE_0;
         2'b01:   price = PRICE_1;
         2'b10:   price = PRICE_2;
         default: code_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_nx        = state;
      credit_nx       = credit;
      timer_nx        = timer;
      coin_accept_nx  = 1'b0;
      coin_reject_nx  = 1'b0;
      insufficient_nx = 1'b0;
      vend_req_nx     = vend_req;
      chg_req_nx      = chg_req;
      to_refund       = 1'b0;
      case (state)
         IDLE: begin
            timer_nx    = '0;
            vend_req_nx = 1'b0;
            chg_req_nx  = 1'b0;
            if (coin_valid) begin
               if (coin_value <= CREDIT_MAX) begin
                  credit_nx      = coin_value;
                  coin_accept_nx = 1'b1;
                  state_nx       = COLLECT;
               end else begin
                  coin_reject_nx = 1'b1;
               end
            end
         end
         COLLECT: begin
            // Priority: cancel > select > coin; a losing coin is handed back.
            if (cancel) begin
               coin_reject_nx = coin_valid;
               timer_nx       = '0;
               to_refund      = 1'b1;
               state_nx       = CHANGE;
            end else if (select_valid) begin
               coin_reject_nx = coin_valid;
               timer_nx       = '0;
               if (code_ok && credit >= price) begin
                  credit_nx   = credit - price;
                  vend_req_nx = 1'b1;
                  state_nx    = VEND;
               end else begin
                  insufficient_nx = 1'b1;
               end
            end else if (coin_valid && coin_sum <= {1'b0, CREDIT_MAX}) begin
               credit_nx      = coin_sum[7:0];
               coin_accept_nx = 1'b1;
               timer_nx       = '0;
            end else begin
               // A rejected coin is not activity, so the timer keeps running.
               coin_reject_nx = coin_valid;
               if (timer == TMO_LAST) begin
                  timer_nx  = '0;
                  to_refund = 1'b1;
                  state_nx  = CHANGE;
               end else begin
                  timer_nx = timer + 1'b1;
               end
            end
         end
         VEND: begin
            coin_reject_nx = coin_valid;
            if (vend_ack) begin
               vend_req_nx = 1'b0;
               if (buy_more && credit != 8'd0) begin
                  timer_nx = '0;
                  state_nx = COLLECT;
               end else if (credit != 8'd0) begin
                  state_nx = CHANGE;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         CHANGE: begin
            coin_reject_nx = coin_valid;
            // After each ack chg_req drops for a cycle before the next coin.
            if (chg_req) begin
               if (chg_ack) begin
                  credit_nx  = credit - CHANGE_UNIT;
                  chg_req_nx = 1'b0;
               end
            end else if (credit >= CHANGE_UNIT) begin
               chg_req_nx = 1'b1;
            end else begin
               credit_nx = 8'd0;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         credit       <= 8'd0;
         timer        <= '0;
         coin_accept  <= 1'b0;
         coin_reject  <= 1'b0;
         insufficient <= 1'b0;
         vend_req     <= 1'b0;
         chg_req      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nx;
         credit       <= credit_nx;
         timer        <= timer_nx;
         coin_accept  <= coin_accept_nx;
         coin_reject  <= coin_reject_nx;
         insufficient <= insufficient_nx;
         vend_req     <= vend_req_nx;
         chg_req      <= chg_req_nx;
         busy         <= (state_nx != IDLE);
      end
   end

`ifdef VEND_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         vend_count   <= 16'd0;
         refund_count <= 16'd0;
      end else begin
         if (state == VEND && vend_ack && vend_count != 16'hFFFF)
            vend_count <= vend_count + 16'd1;
         if (to_refund && refund_count != 16'hFFFF)
            refund_count <= refund_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vend_transaction_controller.sv
module tb_vend_transaction_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic [7:0] coin_value;
   logic       coin_accept, coin_reject;
   logic       select_valid;
   logic [1:0] product_select;
   logic       buy_more, cancel;
   logic       vend_req, vend_ack;
   logic       chg_req, chg_ack;
   logic [7:0] credit;
   logic       insufficient, busy;

   int errors = 0;
   int checks = 0;

   vend_transaction_controller dut (
      .clk(clk), .reset(reset),
      .coin_valid(coin_valid), .coin_value(coin_value),
      .coin_accept(coin_accept), .coin_reject(coin_reject),
      .select_valid(select_valid), .product_select(product_select),
      .buy_more(buy_more), .cancel(cancel),
      .vend_req(vend_req), .vend_ack(vend_ack),
      .chg_req(chg_req), .chg_ack(chg_ack),
      .credit(credit), .insufficient(insufficient), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic coin(input logic [7:0] v);
      coin_valid = 1'b1;
      coin_value = v;
      step();
      coin_valid = 1'b0;
      coin_value = 8'd0;
   endtask

   task automatic sel(input logic [1:0] code);
      select_valid   = 1'b1;
      product_select = code;
      step();
      select_valid   = 1'b0;
   endtask

   task automatic ack(input logic bm);
      vend_ack = 1'b1;
      buy_more = bm;
      step();
      vend_ack = 1'b0;
      buy_more = 1'b0;
   endtask

   task automatic do_cancel();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
   endtask

   // Answers every chg_req until the controller is idle; bounded.
   task automatic drain(input string tag, input int exp_n);
      int n;
      int gap;
      n   = 0;
      gap = 0;
      for (int i = 0; i < 400 && busy; i++) begin
         if (chg_req) begin
            chg_ack = 1'b1;
            step();
            chg_ack = 1'b0;
            n++;
            if (chg_req) gap++;
         end else begin
            step();
         end
      end
      chk({tag, "_handshakes"}, n, exp_n);
      chk({tag, "_req_gap"}, gap, 0);
      chk({tag, "_idle"}, busy, 1'b0);
      chk({tag, "_credit0"}, credit, 8'd0);
      chk({tag, "_req_low"}, chg_req, 1'b0);
   endtask

   task automatic wait_chg(output int cyc);
      cyc = 0;
      while (!chg_req && cyc < 1200) begin
         step();
         cyc++;
      end
   endtask

   initial begin
      int hi;
      int cyc;
      reset = 1'b1; coin_valid = 1'b0; coin_value = 8'd0;
      select_valid = 1'b0; product_select = 2'b00;
      buy_more = 1'b0; cancel = 1'b0; vend_ack = 1'b0; chg_ack = 1'b0;
      step();
      step();
      chk("rst_credit", credit, 8'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_vend_req", vend_req, 1'b0);
      chk("rst_chg_req", chg_req, 1'b0);
      chk("rst_pulses", {coin_accept, coin_reject, insufficient}, 3'b000);
      reset = 1'b0;
      step();

      // Oversized coin in IDLE is rejected.
      coin(8'd201);
      chk("idle_big_reject", coin_reject, 1'b1);
      chk("idle_big_busy", busy, 1'b0);
      chk("idle_big_credit", credit, 8'd0);

      // 25 + 25, select 01, ack after 3 cycles.
      coin(8'd25);
      chk("t1_acc1", coin_accept, 1'b1);
      chk("t1_cr25", credit, 8'd25);
      chk("t1_busy", busy, 1'b1);
      coin(8'd25);
      chk("t1_acc2", coin_accept, 1'b1);
      chk("t1_cr50", credit, 8'd50);
      sel(2'b01);
      chk("t1_cr0", credit, 8'd0);
      hi = int'(vend_req);
      repeat (3) begin
         step();
         hi += int'(vend_req);
      end
      ack(1'b0);
      chk("t1_vreq_cycles", hi, 4);
      chk("t1_vreq_drop", vend_req, 1'b0);
      chk("t1_idle", busy, 1'b0);
      chk("t1_no_chg", chg_req, 1'b0);

      // Coin 100, select 00, ack -> 15 change coins; coin during VEND rejected.
      coin(8'd100);
      sel(2'b00);
      chk("t2_vreq", vend_req, 1'b1);
      chk("t2_cr75", credit, 8'd75);
      coin(8'd5);
      chk("t2_vend_coin_rej", coin_reject, 1'b1);
      chk("t2_vend_coin_cr", credit, 8'd75);
      ack(1'b0);
      chk("t2_vreq_drop", vend_req, 1'b0);
      chk("t2_busy", busy, 1'b1);
      drain("t2", 15);

      // Insufficient credit and invalid code.
      coin(8'd25);
      sel(2'b10);
      chk("t3_insuf", insufficient, 1'b1);
      chk("t3_cr", credit, 8'd25);
      chk("t3_novend", vend_req, 1'b0);
      step();
      chk("t3_insuf_pulse", insufficient, 1'b0);
      chk("t3_collect", busy, 1'b1);
      sel(2'b11);
      chk("t3_insuf_code11", insufficient, 1'b1);
      chk("t3_cr_after11", credit, 8'd25);
      do_cancel();
      drain("t3", 5);

      // Credit 190: overflow coin rejected; select wins over same-cycle coin.
      coin(8'd100);
      coin(8'd90);
      chk("t4_cr190", credit, 8'd190);
      coin(8'd25);
      chk("t4_rej", coin_reject, 1'b1);
      chk("t4_noacc", coin_accept, 1'b0);
      chk("t4_cr190b", credit, 8'd190);
      coin_valid = 1'b1; coin_value = 8'd10;
      select_valid = 1'b1; product_select = 2'b00;
      step();
      coin_valid = 1'b0; select_valid = 1'b0;
      chk("t4_vreq", vend_req, 1'b1);
      chk("t4_coin_rej", coin_reject, 1'b1);
      chk("t4_cr165", credit, 8'd165);
      ack(1'b0);
      drain("t4", 33);

      // Exactly CREDIT_MAX is accepted, one more unit is not.
      coin(8'd195);
      coin(8'd5);
      chk("t5_acc200", coin_accept, 1'b1);
      chk("t5_cr200", credit, 8'd200);
      coin(8'd1);
      chk("t5_rej201", coin_reject, 1'b1);
      chk("t5_cr200b", credit, 8'd200);
      do_cancel();
      drain("t5", 40);

      // Inactivity timeout: CHANGE entered 1000 edges after the coin,
      // chg_req seen one edge later.
      coin(8'd50);
      wait_chg(cyc);
      chk("t6_timeout_cyc", cyc, 1001);
      drain("t6", 10);

      // Cancel at credit 30, and a non-multiple remainder is forfeited.
      coin(8'd30);
      do_cancel();
      drain("t7", 6);
      coin(8'd7);
      do_cancel();
      drain("t7_rem", 1);

      // Buy more keeps residual credit.
      coin(8'd100);
      sel(2'b00);
      ack(1'b1);
      chg_ack = 1'b0;
      chk("t8_cr75", credit, 8'd75);
      chk("t8_busy", busy, 1'b1);
      chk("t8_vreq_drop", vend_req, 1'b0);
      step();
      chk("t8_no_chg", chg_req, 1'b0);
      sel(2'b01);
      chk("t8_vreq2", vend_req, 1'b1);
      chk("t8_cr25", credit, 8'd25);
      ack(1'b0);
      drain("t8", 5);

      // Reset in the middle of CHANGE.
      coin(8'd50);
      do_cancel();
      for (int k = 0; k < 2; k++) begin
         wait_chg(cyc);
         chg_ack = 1'b1;
         step();
         chg_ack = 1'b0;
      end
      chk("t9_cr40", credit, 8'd40);
      wait_chg(cyc);
      chk("t9_req_before_rst", chg_req, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t9_chg_req0", chg_req, 1'b0);
      chk("t9_credit0", credit, 8'd0);
      chk("t9_busy0", busy, 1'b0);
      chk("t9_others0", {vend_req, coin_accept, coin_reject, insufficient}, 4'b0000);
      step();
      chk("t9_stay_idle", {busy, chg_req}, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
